// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared state type and width helpers for fifo_push_arbiter.
package fifo_arb_pkg;
   typedef enum logic {IDLE, BURST} arb_state_t;
   localparam int STAT_W = 16;
   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set req scanning from ptr upward mod N.
module rr_pick import fifo_arb_pkg::*; #(
   parameter int N = 4,
   localparam int PW = ptr_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic          valid,
   output logic [PW-1:0] winner
);
   // Scan farthest offset first so the nearest requester overwrites it.
   always_comb begin
      winner = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % N]) winner = PW'((int'(ptr) + i) % N);
   end
   assign valid = |req;
endmodule

// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin share of one fifo_flops write port with optional locked bursts.
// Define FIFO_ARB_STATS_EN to add saturating grant_cnt/stall_cnt outputs.
module fifo_push_arbiter import fifo_arb_pkg::*; #(
   parameter int N         = 4,
   parameter int width     = 16,
   parameter int MAX_BURST = 4,
   localparam int PW = ptr_w(N),
   localparam int CW = cnt_w(MAX_BURST)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N-1:0]       lock,
   input  logic [N*width-1:0] din_req,
   output logic [N-1:0]       gnt,
   output logic               push,
   output logic [width-1:0]   Din,
   input  logic               full,
   output logic [PW-1:0]      owner,
   output logic               busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [N*STAT_W-1:0] grant_cnt,
   output logic [STAT_W-1:0]   stall_cnt
`endif
);
   arb_state_t    r_state, w_state_nxt;
   logic [PW-1:0] r_rr_ptr, w_rr_ptr_nxt, r_owner, w_owner_nxt, w_pick, w_sel;
   logic [CW-1:0] r_burst_cnt, w_burst_cnt_nxt;
   logic          w_pick_valid;

   rr_pick #(.N(N)) u_pick (
      .req    (req),
      .ptr    (r_rr_ptr),
      .valid  (w_pick_valid),
      .winner (w_pick)
   );

   assign w_sel = (r_state == BURST) ? r_owner : w_pick;
   assign push  = |gnt;
   assign Din   = push ? din_req[w_sel*width +: width] : '0;
   assign owner = r_owner;
   assign busy  = (r_state == BURST);

   always_comb begin
      w_state_nxt     = r_state;
      w_rr_ptr_nxt    = r_rr_ptr;
      w_owner_nxt     = r_owner;
      w_burst_cnt_nxt = r_burst_cnt;
      gnt             = '0;
      if (!rst && !full) begin
         if (r_state == IDLE) begin
            if (w_pick_valid) begin
               gnt[w_pick]  = 1'b1;
               w_rr_ptr_nxt = (w_pick == PW'(N - 1)) ? '0 : w_pick + 1'b1;
               if (lock[w_pick] && MAX_BURST > 1) begin
                  w_state_nxt     = BURST;
                  w_owner_nxt     = w_pick;
                  w_burst_cnt_nxt = CW'(1);
               end
            end
         end else begin
            // A missing owner word ends the burst with a bubble instead of granting others.
            gnt[r_owner]    = req[r_owner];
            w_burst_cnt_nxt = r_burst_cnt + 1'b1;
            if (!req[r_owner] || !lock[r_owner] || w_burst_cnt_nxt == CW'(MAX_BURST)) begin
               w_state_nxt     = IDLE;
               w_burst_cnt_nxt = '0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_owner     <= w_owner_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         for (int k = 0; k < N; k++)
            if (gnt[k] && grant_cnt[k*STAT_W +: STAT_W] != '1)
               grant_cnt[k*STAT_W +: STAT_W] <= grant_cnt[k*STAT_W +: STAT_W] + 1'b1;
         if (|req && full && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif
endmodule
